// File: rtl/pc_flow_ctrl_pkg.sv
// rtl/pc_flow_ctrl_pkg.sv - shared types and defaults for the PC flow controller
package pc_flow_ctrl_pkg;

  localparam int          DEF_ADDR_W     = 32;
  localparam logic [31:0] DEF_EXC_VECTOR = 32'h0000_0100;
  localparam int          DEF_MDU_CYCLES = 32;

  typedef enum logic [1:0] {
    ST_BOOT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MDU_WAIT = 2'd2
  } state_t;

  // Encoded in ascending priority so a plain magnitude compare ranks redirects.
  typedef enum logic [1:0] {
    RK_NONE   = 2'd0,
    RK_JUMP   = 2'd1,
    RK_BRANCH = 2'd2,
    RK_EXC    = 2'd3
  } rkind_t;

  // Jumps resolve in ID, so only IF/ID holds a wrong-path instruction; later
  // redirects also have a wrong-path instruction sitting in ID/EX.
  function automatic logic kind_flushes_id_ex(rkind_t kind);
    return (kind == RK_BRANCH) || (kind == RK_EXC);
  endfunction

endpackage

// File: rtl/pc_flow_ctrl_if.sv
// rtl/pc_flow_ctrl_if.sv - hazard/branch side to PC register control bundle
interface pc_flow_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              inited;
  logic              exc_req;
  logic              ex_br_taken;
  logic [ADDR_W-1:0] ex_br_target;
  logic              id_jump;
  logic [ADDR_W-1:0] id_jump_target;
  logic              load_use;
  logic              mem_busy;
  logic              mdu_start;
  logic              pc_stall;
  logic              pc_branch_flag;
  logic [ADDR_W-1:0] pc_branch_addr;
  logic              flush_if_id;
  logic              flush_id_ex;
  logic              bubble_id_ex;
  logic              mdu_busy;

  modport master (
    output inited, exc_req, ex_br_taken, ex_br_target, id_jump, id_jump_target,
           load_use, mem_busy, mdu_start,
    input  pc_stall, pc_branch_flag, pc_branch_addr, flush_if_id, flush_id_ex,
           bubble_id_ex, mdu_busy
  );

  modport slave (
    input  inited, exc_req, ex_br_taken, ex_br_target, id_jump, id_jump_target,
           load_use, mem_busy, mdu_start,
    output pc_stall, pc_branch_flag, pc_branch_addr, flush_if_id, flush_id_ex,
           bubble_id_ex, mdu_busy
  );
endinterface

// File: rtl/pc_redirect_arb.sv
// rtl/pc_redirect_arb.sv - priority mux over exception, EX branch and ID jump redirects
module pc_redirect_arb
  import pc_flow_ctrl_pkg::*;
#(
  parameter int              ADDR_W     = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(DEF_EXC_VECTOR)
) (
  input  logic              exc_req,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  output logic              valid,
  output rkind_t            kind,
  output logic [ADDR_W-1:0] addr
);

  // Fixed priority: exception, then EX branch, then ID jump.
  always_comb begin
    valid = 1'b0;
    kind  = RK_NONE;
    addr  = '0;
    if (exc_req) begin
      valid = 1'b1;
      kind  = RK_EXC;
      addr  = EXC_VECTOR;
    end else if (br_taken) begin
      valid = 1'b1;
      kind  = RK_BRANCH;
      addr  = br_target;
    end else if (jump) begin
      valid = 1'b1;
      kind  = RK_JUMP;
      addr  = jump_target;
    end
  end

endmodule

// File: rtl/pc_flow_ctrl.sv
// rtl/pc_flow_ctrl.sv - PC stall/redirect sequencer with pipeline flush and bubble control
module pc_flow_ctrl
  import pc_flow_ctrl_pkg::*;
#(
  parameter int                ADDR_W     = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = ADDR_W'(DEF_EXC_VECTOR),
  parameter int                MDU_CYCLES = DEF_MDU_CYCLES
) (
  input logic           clk,
  input logic           rst,
  pc_flow_ctrl_if.slave bus
);

  localparam int CNT_W = (MDU_CYCLES > 2) ? $clog2(MDU_CYCLES) : 1;

  state_t            state, next_state;
  logic [CNT_W-1:0]  cnt, cnt_next;
  logic              pend_valid, pend_valid_next;
  rkind_t            pend_kind, pend_kind_next;
  logic [ADDR_W-1:0] pend_addr, pend_addr_next;

  logic              req_valid;
  rkind_t            req_kind;
  logic [ADDR_W-1:0] req_addr;

  // A jump behind a load-use hazard is not taken yet; it is re-presented once
  // the hazard clears, so it must not reach the arbiter or the pend register.
  pc_redirect_arb #(
    .ADDR_W     (ADDR_W),
    .EXC_VECTOR (EXC_VECTOR)
  ) u_arb (
    .exc_req     (bus.exc_req),
    .br_taken    (bus.ex_br_taken),
    .br_target   (bus.ex_br_target),
    .jump        (bus.id_jump & ~bus.load_use),
    .jump_target (bus.id_jump_target),
    .valid       (req_valid),
    .kind        (req_kind),
    .addr        (req_addr)
  );

  // State, MDU counter and pending redirect; loss of inited behaves like reset.
  always_ff @(posedge clk) begin
    if (rst || !bus.inited) begin
      state      <= ST_BOOT;
      cnt        <= '0;
      pend_valid <= 1'b0;
      pend_kind  <= RK_NONE;
      pend_addr  <= '0;
    end else begin
      state      <= next_state;
      cnt        <= cnt_next;
      pend_valid <= pend_valid_next;
      pend_kind  <= pend_kind_next;
      pend_addr  <= pend_addr_next;
    end
  end

  // Next-state and control outputs; any redirect drops pc_stall.
  always_comb begin
    next_state          = state;
    cnt_next            = cnt;
    pend_valid_next     = pend_valid;
    pend_kind_next      = pend_kind;
    pend_addr_next      = pend_addr;
    bus.pc_stall        = 1'b0;
    bus.pc_branch_flag  = 1'b0;
    bus.pc_branch_addr  = '0;
    bus.flush_if_id     = 1'b0;
    bus.flush_id_ex     = 1'b0;
    bus.bubble_id_ex    = 1'b0;
    bus.mdu_busy        = 1'b0;

    case (state)
      ST_BOOT: begin
        bus.pc_stall    = 1'b1;
        bus.flush_if_id = 1'b1;
        bus.flush_id_ex = 1'b1;
        next_state      = ST_RUN;
      end

      ST_RUN: begin
        if (bus.mem_busy) begin
          // Whole pipe holds; remember the strongest redirect seen so far.
          bus.pc_stall = 1'b1;
          if (req_valid && (!pend_valid || req_kind >= pend_kind)) begin
            pend_valid_next = 1'b1;
            pend_kind_next  = req_kind;
            pend_addr_next  = req_addr;
          end
        end else if (pend_valid && !bus.exc_req) begin
          bus.pc_branch_flag = 1'b1;
          bus.pc_branch_addr = pend_addr;
          bus.flush_if_id    = 1'b1;
          bus.flush_id_ex    = kind_flushes_id_ex(pend_kind);
          pend_valid_next    = 1'b0;
        end else if (req_valid && req_kind != RK_JUMP) begin
          bus.pc_branch_flag = 1'b1;
          bus.pc_branch_addr = req_addr;
          bus.flush_if_id    = 1'b1;
          bus.flush_id_ex    = 1'b1;
          pend_valid_next    = 1'b0;
        end else if (bus.mdu_start) begin
          // The start cycle is the first of the MDU_CYCLES stall cycles.
          bus.pc_stall = 1'b1;
          cnt_next     = CNT_W'(MDU_CYCLES - 2);
          next_state   = ST_MDU_WAIT;
        end else if (bus.load_use) begin
          bus.pc_stall     = 1'b1;
          bus.bubble_id_ex = 1'b1;
        end else if (req_valid) begin
          bus.pc_branch_flag = 1'b1;
          bus.pc_branch_addr = req_addr;
          bus.flush_if_id    = 1'b1;
        end
      end

      ST_MDU_WAIT: begin
        bus.mdu_busy = 1'b1;
        bus.pc_stall = 1'b1;
        if (bus.exc_req) begin
          next_state = ST_RUN;
          if (bus.mem_busy) begin
            // Cannot redirect into a held pipe; replay it from RUN.
            pend_valid_next = 1'b1;
            pend_kind_next  = RK_EXC;
            pend_addr_next  = EXC_VECTOR;
          end else begin
            bus.pc_stall       = 1'b0;
            bus.pc_branch_flag = 1'b1;
            bus.pc_branch_addr = EXC_VECTOR;
            bus.flush_if_id    = 1'b1;
            bus.flush_id_ex    = 1'b1;
          end
        end else if (!bus.mem_busy) begin
          if (cnt == '0) begin
            next_state = ST_RUN;
          end else begin
            cnt_next = cnt - CNT_W'(1);
          end
        end
      end

      default: begin
        next_state = ST_BOOT;
      end
    endcase
  end

endmodule
